// File: rtl/truth_table_checker.sv
// Sweeps a 3-input unit under test against an expected truth table.
// Optional CHECKER_ORDER_EN adds strict ascending code-order checking.
module truth_table_checker #(
  parameter logic [7:0] EXP_TABLE = 8'b1110_1000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [2:0] in_data,
  input  logic       in_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [3:0] mismatch_cnt,
  output logic [7:0] seen_mask,
  output logic       err_valid,
  output logic [2:0] first_err_idx,
  output logic       order_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0] TO_LIM = TIMEOUT[7:0];

  state_t     state_q, state_d;
  logic [7:0] seen_q, seen_d;
  logic [3:0] mm_q, mm_d;
  logic       ev_q, ev_d;
  logic [2:0] fe_q, fe_d;
  logic       to_q, to_d;
  logic [7:0] idle_q, idle_d;
  logic       fresh;
  logic       wrong;

  assign fresh = ~seen_q[in_data];
  assign wrong = in_y != EXP_TABLE[in_data];

`ifdef CHECKER_ORDER_EN
  logic       oe_q, oe_d;
  logic [2:0] prev_q, prev_d;
`endif

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    mm_d    = mm_q;
    ev_d    = ev_q;
    fe_d    = fe_q;
    to_d    = to_q;
    idle_d  = idle_q;
`ifdef CHECKER_ORDER_EN
    oe_d    = oe_q;
    prev_d  = prev_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          seen_d  = '0;
          mm_d    = '0;
          ev_d    = 1'b0;
          fe_d    = '0;
          to_d    = 1'b0;
          idle_d  = '0;
`ifdef CHECKER_ORDER_EN
          oe_d    = 1'b0;
          prev_d  = '0;
`endif
        end
      end
      RUN: begin
        if (in_valid) begin
          idle_d = '0;
          if (fresh) begin
            seen_d = seen_q | (8'd1 << in_data);
            if (wrong) begin
              mm_d = mm_q + 4'd1;
              if (!ev_q) begin
                ev_d = 1'b1;
                fe_d = in_data;
              end
            end
`ifdef CHECKER_ORDER_EN
            // first compared sample of a sweep has no predecessor
            if (seen_q != 8'h00 && in_data != prev_q + 3'd1)
              oe_d = 1'b1;
            prev_d = in_data;
`endif
            if (seen_d == 8'hFF) state_d = DONE;
          end
        end else begin
          idle_d = idle_q + 8'd1;
          if (idle_d >= TO_LIM) begin
            to_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seen_q  <= '0;
      mm_q    <= '0;
      ev_q    <= 1'b0;
      fe_q    <= '0;
      to_q    <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      mm_q    <= mm_d;
      ev_q    <= ev_d;
      fe_q    <= fe_d;
      to_q    <= to_d;
      idle_q  <= idle_d;
    end
  end

`ifdef CHECKER_ORDER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_q   <= 1'b0;
      prev_q <= '0;
    end else begin
      oe_q   <= oe_d;
      prev_q <= prev_d;
    end
  end

  assign order_err = oe_q;
`else
  assign order_err = 1'b0;
`endif

  assign busy          = state_q == RUN;
  assign done          = state_q == DONE;
  assign pass          = done && mm_q == 4'd0 && !to_q && !order_err;
  assign timeout       = to_q;
  assign mismatch_cnt  = mm_q;
  assign seen_mask     = seen_q;
  assign err_valid     = ev_q;
  assign first_err_idx = fe_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: directed sweeps plus random traffic
// compared each cycle against a table-level reference model.
module tb_truth_table_checker;

  localparam logic [7:0] EXP = 8'b1110_1000;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_data = '0;
  logic       in_y = 1'b0;
  logic       busy, done, pass, timeout, err_valid, order_err;
  logic [3:0] mismatch_cnt;
  logic [7:0] seen_mask;
  logic [2:0] first_err_idx;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

`ifdef CHECKER_ORDER_EN
  localparam bit ORD = 1'b1;
`else
  localparam bit ORD = 1'b0;
`endif

  truth_table_checker #(.EXP_TABLE(EXP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_y(in_y),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .mismatch_cnt(mismatch_cnt), .seen_mask(seen_mask),
    .err_valid(err_valid), .first_err_idx(first_err_idx),
    .order_err(order_err)
  );

  always #5 clk = ~clk;

  // reference model: 0 idle, 1 run, 2 done
  int m_st, m_mm, m_fe, m_idle, m_prev, m_cmp;
  bit m_seen [8];
  bit m_ev, m_to, m_oe;

  function automatic int seen_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += m_seen[i];
    return n;
  endfunction

  function automatic int seen_bits();
    int v = 0;
    for (int i = 0; i < 8; i++) if (m_seen[i]) v += (1 << i);
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
    m_mm = 0; m_fe = 0; m_idle = 0; m_prev = 0; m_cmp = 0;
    m_ev = 0; m_to = 0; m_oe = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clear();
      m_st = 0;
    end else if (m_st != 1) begin
      if (start) begin
        m_clear();
        m_st = 1;
      end
    end else if (in_valid) begin
      m_idle = 0;
      if (!m_seen[in_data]) begin
        if (ORD && m_cmp > 0 && int'(in_data) != (m_prev + 1) % 8)
          m_oe = 1;
        m_prev = in_data;
        m_cmp++;
        m_seen[in_data] = 1;
        if (in_y != EXP[in_data]) begin
          m_mm++;
          if (!m_ev) begin
            m_ev = 1;
            m_fe = in_data;
          end
        end
        if (seen_count() == 8) m_st = 2;
      end
    end else begin
      m_idle++;
      if (m_idle >= TMO) begin
        m_to = 1;
        m_st = 2;
      end
    end
  end

  task automatic check(string nm, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      bit mp;
      mp = m_st == 2 && m_mm == 0 && !m_to && !m_oe;
      check("cyc_busy", busy, m_st == 1);
      check("cyc_done", done, m_st == 2);
      check("cyc_pass", pass, mp);
      check("cyc_timeout", timeout, m_to);
      check("cyc_mm", mismatch_cnt, m_mm);
      check("cyc_seen", seen_mask, seen_bits());
      check("cyc_ev", err_valid, m_ev);
      check("cyc_fe", first_err_idx, m_fe);
      check("cyc_oe", order_err, m_oe);
    end
  end

  task automatic drive(bit s, bit v, int d, bit y);
    start = s;
    in_valid = v;
    in_data = 3'(d);
    in_y = y;
    @(posedge clk);
    #1;
    start = 0;
    in_valid = 0;
  endtask

  task automatic sample(int d, bit flip);
    logic [7:0] t = EXP;
    drive(0, 1, d, t[d] ^ flip);
  endtask

  task automatic clean_sweep();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) sample(i, 0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_seen", seen_mask, 0);
    check("rst_mm", mismatch_cnt, 0);
    check("rst_ev", err_valid, 0);
    @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst_n = 1;
    @(posedge clk);
    #1;
    cmp_en = 1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_seen", seen_mask, 0);
    // no sweep without start
    sample(0, 0);
    check("idle_ignore", seen_mask, 0);

    // clean sweep: done 9 cycles after start
    drive(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) sample(i, 0);
    check("s1_not_done", done, 0);
    sample(7, 0);
    check("s1_done", done, 1);
    check("s1_pass", pass, 1);
    check("s1_mm", mismatch_cnt, 0);
    check("s1_seen", seen_mask, 8'hFF);

    // codes 2 and 5 wrong
    drive(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) sample(i, i == 2 || i == 5);
    check("s2_mm", mismatch_cnt, 2);
    check("s2_fe", first_err_idx, 2);
    check("s2_ev", err_valid, 1);
    check("s2_pass", pass, 0);
    // hold in DONE
    sample(0, 1);
    check("s2_hold", mismatch_cnt, 2);

    // duplicate with wrong y ignored
    drive(1, 0, 0, 0);
    sample(0, 0);
    sample(1, 0);
    sample(1, 1);
    for (int i = 2; i < 8; i++) sample(i, 0);
    check("s3_mm", mismatch_cnt, 0);
    check("s3_pass", pass, 1);

    // timeout
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) sample(i, 0);
    for (int i = 0; i < 15; i++) drive(0, 0, 0, 0);
    check("s4_not_done", done, 0);
    drive(0, 0, 0, 0);
    check("s4_done", done, 1);
    check("s4_to", timeout, 1);
    check("s4_seen", seen_mask, 8'h0F);
    check("s4_pass", pass, 0);

    // reset mid-sweep, then clean restart
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) sample(i, 0);
    pulse_reset();
    check("s5_idle", busy, 0);
    clean_sweep();
    check("s5_pass", pass, 1);

    // out-of-order sequence
    drive(1, 0, 0, 0);
    sample(0, 0); sample(1, 0); sample(3, 0); sample(2, 0);
    for (int i = 4; i < 8; i++) sample(i, 0);
    check("s6_done", done, 1);
    check("s6_oe", order_err, ORD);
    check("s6_pass", pass, !ORD);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      int quiet;
      if (n % 700 == 350) pulse_reset();
      quiet = ($urandom_range(0, 99) < 3) ? $urandom_range(10, 20) : 0;
      for (int q = 0; q < quiet; q++) drive(0, 0, 0, 0);
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 7), $urandom_range(0, 7) == 0 ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
